if_fetch_stage: RTL and testbench

- Instruction-fetch stage of the MIPS 5-stage pipeline. Sits directly upstream of the instruction memory and feeds the IF/ID boundary.
- Owns the PC register and drives the imem chip-enable and address. Captures the returned instruction into the IF/ID pipeline register.
- Applies stall (hold), flush (bubble) and redirect (branch/jump target) requests from later stages.

---
 rtl/if_fetch_stage_if.sv | 37 +++
 rtl/if_fetch_stage.sv | 145 ++++++++++++++
 tb/tb_if_fetch_stage.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
// -----------------------------------------------------------------------------
// if_fetch_stage_if
// Instruction-memory bus between the fetch stage and the imem.
//
// Signals:
//   if_o_im_ce     fetch -> imem  chip-enable
//   if_o_im_addr   fetch -> imem  fetch address (the PC)
//   if_i_im_instr  imem -> fetch  returned instruction word
//   if_i_im_ce     imem -> fetch  returned word is valid
//
// Modports:
//   master  fetch-stage side
//   slave   imem side
// -----------------------------------------------------------------------------
interface if_fetch_stage_if #(
  parameter int PC_WIDTH = 32,
  parameter int IWIDTH   = 32
);
  logic                if_o_im_ce;
  logic [PC_WIDTH-1:0] if_o_im_addr;
  logic [IWIDTH-1:0]   if_i_im_instr;
  logic                if_i_im_ce;

  modport master (
    output if_o_im_ce,
    output if_o_im_addr,
    input  if_i_im_instr,
    input  if_i_im_ce
  );

  modport slave (
    input  if_o_im_ce,
    input  if_o_im_addr,
    output if_i_im_instr,
    output if_i_im_ce
  );
endinterface

// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
// Instruction-fetch stage of a 5-stage MIPS pipeline. Owns the PC, drives the
// imem chip-enable/address and captures the returned word into the IF/ID
// register. Applies redirect > stall > flush > normal-advance each cycle.
//
// Optional feature macro: IF_MISALIGN_CHK_EN
//   defined   : a redirect whose target has non-zero low bits sets a sticky
//               if_o_misalign flag (cleared only by reset).
//   undefined : if_o_misalign is tied to 0.
//
// Ports:
//   if_clk         pipeline clock (posedge)
//   im_rst         asynchronous, active-low reset
//   if_i_stall     hold PC and IF/ID
//   if_i_flush     replace IF/ID with a bubble
//   if_i_redirect  load PC from if_i_target
//   if_i_target    redirect target
//   im_bus         imem bus (master side): ce/addr out, instr/valid in
//   if_o_id_instr  IF/ID instruction (0 when not valid)
//   if_o_id_pc     IF/ID PC
//   if_o_id_pc4    IF/ID PC+4 (wraps)
//   if_o_id_valid  IF/ID holds a real instruction
//   if_o_misalign  sticky misaligned-redirect flag
// -----------------------------------------------------------------------------
module if_fetch_stage #(
  parameter int                  PC_WIDTH = 32,
  parameter int                  IWIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                if_clk,
  input  logic                im_rst,
  input  logic                if_i_stall,
  input  logic                if_i_flush,
  input  logic                if_i_redirect,
  input  logic [PC_WIDTH-1:0] if_i_target,
  if_fetch_stage_if.master    im_bus,
  output logic [IWIDTH-1:0]   if_o_id_instr,
  output logic [PC_WIDTH-1:0] if_o_id_pc,
  output logic [PC_WIDTH-1:0] if_o_id_pc4,
  output logic                if_o_id_valid,
  output logic                if_o_misalign
);

  typedef enum logic {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t              state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic                im_ce_q;
  logic [IWIDTH-1:0]   id_instr_q;
  logic [PC_WIDTH-1:0] id_pc_q;
  logic [PC_WIDTH-1:0] id_pc4_q;
  logic                id_valid_q;

  // Sequential PC; natural wrap of the adder gives the modulo-2^PC_WIDTH rule.
  logic [PC_WIDTH-1:0] pc_seq_d;
  assign pc_seq_d = pc_q + PC_WIDTH'(4);

  // Redirect target with the byte-offset bits dropped.
  logic [PC_WIDTH-1:0] target_aligned_d;
  assign target_aligned_d = {if_i_target[PC_WIDTH-1:2], 2'b00};

`ifdef IF_MISALIGN_CHK_EN
  logic misalign_q;
`else
  logic unused_target_lo;
  assign unused_target_lo = ^if_i_target[1:0];
`endif

  always_ff @(posedge if_clk or negedge im_rst) begin
    if (!im_rst) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      im_ce_q    <= 1'b0;
      id_instr_q <= '0;
      id_pc_q    <= '0;
      id_pc4_q   <= '0;
      id_valid_q <= 1'b0;
`ifdef IF_MISALIGN_CHK_EN
      misalign_q <= 1'b0;
`endif
    end else if (state_q == S_BOOT) begin
      // One idle cycle lets the imem image settle; all requests ignored.
      state_q <= S_RUN;
      im_ce_q <= 1'b1;
    end else begin
      // ce stays high even while stalled: the imem blanks its output when
      // ce is low, which would corrupt the word we resume with.
      im_ce_q <= 1'b1;
      if (if_i_redirect) begin
        pc_q       <= target_aligned_d;
        id_instr_q <= '0;
        id_pc_q    <= '0;
        id_pc4_q   <= '0;
        id_valid_q <= 1'b0;
`ifdef IF_MISALIGN_CHK_EN
        if (|if_i_target[1:0]) begin
          misalign_q <= 1'b1;
        end
`endif
      end else if (if_i_stall) begin
        // PC held; IF/ID held unless a flush lands in the same cycle.
        if (if_i_flush) begin
          id_instr_q <= '0;
          id_pc_q    <= '0;
          id_pc4_q   <= '0;
          id_valid_q <= 1'b0;
        end
      end else if (if_i_flush) begin
        pc_q       <= pc_seq_d;
        id_instr_q <= '0;
        id_pc_q    <= '0;
        id_pc4_q   <= '0;
        id_valid_q <= 1'b0;
      end else begin
        // An invalid imem return captures a nop so decode needs no gating,
        // and the PC is held so the same address is re-fetched.
        id_instr_q <= im_bus.if_i_im_ce ? im_bus.if_i_im_instr : '0;
        id_pc_q    <= pc_q;
        id_pc4_q   <= pc_seq_d;
        id_valid_q <= im_bus.if_i_im_ce;
        if (im_bus.if_i_im_ce) begin
          pc_q <= pc_seq_d;
        end
      end
    end
  end

  assign im_bus.if_o_im_ce   = im_ce_q;
  assign im_bus.if_o_im_addr = pc_q;
  assign if_o_id_instr       = id_instr_q;
  assign if_o_id_pc          = id_pc_q;
  assign if_o_id_pc4         = id_pc4_q;
  assign if_o_id_valid       = id_valid_q;

`ifdef IF_MISALIGN_CHK_EN
  assign if_o_misalign = misalign_q;
`else
  assign if_o_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_stage
// Scoreboard bench for if_fetch_stage: a reference model predicts the
// registered outputs after each posedge and queues them; a negedge monitor
// pops and compares. A small imem responder serves words from a fixed image.
// -----------------------------------------------------------------------------
module tb_if_fetch_stage;

  logic        if_clk = 1'b0;
  logic        im_rst = 1'b0;
  logic        if_i_stall = 1'b0;
  logic        if_i_flush = 1'b0;
  logic        if_i_redirect = 1'b0;
  logic [31:0] if_i_target = '0;
  logic [31:0] if_o_id_instr;
  logic [31:0] if_o_id_pc;
  logic [31:0] if_o_id_pc4;
  logic        if_o_id_valid;
  logic        if_o_misalign;
  bit          imem_ok = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 if_clk = ~if_clk;

  if_fetch_stage_if #(.PC_WIDTH(32), .IWIDTH(32)) im_bus ();

  if_fetch_stage #(.PC_WIDTH(32), .IWIDTH(32), .RESET_PC(32'h0)) dut (
    .if_clk       (if_clk),
    .im_rst       (im_rst),
    .if_i_stall   (if_i_stall),
    .if_i_flush   (if_i_flush),
    .if_i_redirect(if_i_redirect),
    .if_i_target  (if_i_target),
    .im_bus       (im_bus),
    .if_o_id_instr(if_o_id_instr),
    .if_o_id_pc   (if_o_id_pc),
    .if_o_id_pc4  (if_o_id_pc4),
    .if_o_id_valid(if_o_id_valid),
    .if_o_misalign(if_o_misalign)
  );

  // imem image: first four words fixed, the rest a hash of the address.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h20080001;
      32'h4:   return 32'h20090002;
      32'h8:   return 32'h01095020;
      32'hC:   return 32'h00000000;
      default: return (a * 32'h9E3779B1) ^ 32'h13572468;
    endcase
  endfunction

  // imem responder: samples address on negedge, answers before next posedge.
  initial begin
    im_bus.if_i_im_instr = '0;
    im_bus.if_i_im_ce    = 1'b0;
  end
  always @(negedge if_clk) begin
    if (im_bus.if_o_im_ce && imem_ok) begin
      im_bus.if_i_im_instr = imem_word(im_bus.if_o_im_addr);
      im_bus.if_i_im_ce    = 1'b1;
    end else begin
      im_bus.if_i_im_instr = '0;
      im_bus.if_i_im_ce    = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [31:0] ce;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] valid;
    logic [31:0] mis;
  } exp_t;

  exp_t        exp_q[$];
  bit          m_running;
  logic [31:0] m_pc;
  logic [31:0] m_instr, m_idpc, m_idpc4;
  bit          m_valid, m_mis;

  always @(posedge if_clk or negedge im_rst) begin
    exp_t e;
    if (!im_rst) begin
      m_running = 1'b0;
      m_pc      = 32'h0;
      m_instr   = 0; m_idpc = 0; m_idpc4 = 0; m_valid = 0; m_mis = 0;
      exp_q.delete();
    end else begin
      if (!m_running) begin
        m_running = 1'b1;
      end else if (if_i_redirect) begin
        m_pc    = if_i_target & ~32'h3;
        m_instr = 0; m_idpc = 0; m_idpc4 = 0; m_valid = 0;
`ifdef IF_MISALIGN_CHK_EN
        if (if_i_target % 4 != 0) m_mis = 1'b1;
`endif
      end else if (if_i_stall) begin
        if (if_i_flush) begin
          m_instr = 0; m_idpc = 0; m_idpc4 = 0; m_valid = 0;
        end
      end else if (if_i_flush) begin
        m_instr = 0; m_idpc = 0; m_idpc4 = 0; m_valid = 0;
        m_pc    = m_pc + 4;
      end else if (imem_ok) begin
        m_instr = imem_word(m_pc);
        m_idpc  = m_pc;
        m_idpc4 = m_pc + 4;
        m_valid = 1'b1;
        m_pc    = m_pc + 4;
      end else begin
        m_instr = 0;
        m_idpc  = m_pc;
        m_idpc4 = m_pc + 4;
        m_valid = 1'b0;
      end
      e.ce = 1; e.addr = m_pc; e.instr = m_instr; e.pc = m_idpc;
      e.pc4 = m_idpc4; e.valid = 32'(m_valid); e.mis = 32'(m_mis);
      exp_q.push_back(e);
    end
  end

  always @(negedge if_clk) begin
    exp_t e;
    if (im_rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("im_ce",    32'(im_bus.if_o_im_ce), e.ce);
      chk("im_addr",  im_bus.if_o_im_addr,    e.addr);
      chk("id_valid", 32'(if_o_id_valid),     e.valid);
      chk("id_instr", if_o_id_instr,          e.instr);
      chk("id_pc",    if_o_id_pc,             e.pc);
      chk("id_pc4",   if_o_id_pc4,            e.pc4);
      chk("misalign", 32'(if_o_misalign),     e.mis);
      $display("cyc t=%0t addr=%h id=(%h,%h,%h,v%0d) mis=%0d",
               $time, im_bus.if_o_im_addr, if_o_id_instr, if_o_id_pc,
               if_o_id_pc4, if_o_id_valid, if_o_misalign);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit st, input bit fl, input bit rd,
                     input logic [31:0] tg, input bit ok);
    if_i_stall    = st;
    if_i_flush    = fl;
    if_i_redirect = rd;
    if_i_target   = tg;
    imem_ok       = ok;
    @(posedge if_clk);
    #2;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ce"},    32'(im_bus.if_o_im_ce), 32'h0);
    chk({tag, "_addr"},  im_bus.if_o_im_addr,    32'h0);
    chk({tag, "_instr"}, if_o_id_instr,          32'h0);
    chk({tag, "_pc"},    if_o_id_pc,             32'h0);
    chk({tag, "_pc4"},   if_o_id_pc4,            32'h0);
    chk({tag, "_valid"}, 32'(if_o_id_valid),     32'h0);
    chk({tag, "_mis"},   32'(if_o_misalign),     32'h0);
  endtask

  task automatic release_and_boot();
    @(posedge if_clk);
    #2;
    im_rst = 1'b1;
    @(negedge if_clk);
    chk("boot_ce", 32'(im_bus.if_o_im_ce), 32'h0);
    @(posedge if_clk);
    #2;
  endtask

  task automatic random_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] tg;
      tg = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 255));
      cyc($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10,
          $urandom_range(0, 99) < 10, tg, $urandom_range(0, 99) < 85);
    end
  endtask

  initial begin
    #1;
    check_reset_outputs("rst0");
    release_and_boot();

    // Directed sequence following the bring-up scenarios.
    cyc(0, 0, 0, 32'h0, 1);          // (0x20080001, 0, 4)
    cyc(0, 0, 0, 32'h0, 1);          // (0x20090002, 4, 8)
    cyc(1, 0, 0, 32'h0, 1);          // stall, PC 8 held
    cyc(1, 0, 0, 32'h0, 1);
    cyc(0, 0, 0, 32'h0, 1);          // (0x01095020, 8, 0xC)
    cyc(1, 0, 1, 32'h40, 1);         // redirect beats stall
    cyc(0, 0, 0, 32'h0, 1);          // (.., 0x40, 0x44)
    cyc(0, 0, 1, 32'h10, 1);
    cyc(0, 1, 0, 32'h0, 1);          // flush at 0x10 -> PC 0x14
    cyc(0, 0, 0, 32'h0, 0);          // imem not valid: PC held
    cyc(0, 0, 0, 32'h0, 1);
    cyc(1, 1, 0, 32'h0, 1);          // stall+flush: bubble, PC held
    cyc(0, 0, 0, 32'h0, 1);
    cyc(0, 0, 1, 32'hFFFFFFFC, 1);
    cyc(0, 0, 0, 32'h0, 1);          // pc=FFFFFFFC pc4=0, next addr 0
    cyc(0, 0, 0, 32'h0, 1);
    cyc(0, 0, 1, 32'h42, 1);         // misaligned redirect -> PC 0x40
    cyc(0, 0, 0, 32'h0, 1);
    cyc(0, 0, 0, 32'h0, 1);

    random_cycles(3000);

    // Mid-operation asynchronous reset.
    im_rst = 1'b0;
    #1;
    check_reset_outputs("rst1");
    release_and_boot();
    random_cycles(800);

    @(negedge if_clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
